// File: rtl/regfile_wb_pkg.sv
// ----------------------------------------------------------------------------
// regfile_wb_pkg
// Shared definitions for the register-file writeback arbiter and its
// scoreboard: register-file geometry, the arbiter state encoding and a
// saturating increment used by the starvation counter.
// No ports (package).
// ----------------------------------------------------------------------------
package regfile_wb_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int REG_DATA_W   = 32;
    localparam int NUM_REGS     = 32;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic [0:0] {
        ST_ALU_PRI  = 1'b0,
        ST_MD_FORCE = 1'b1
    } state_t;

    // Increment that sticks at all-ones so a long starvation run cannot wrap.
    function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
        if (v == {STARVE_CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Busy-bit scoreboard for outstanding multdiv destinations.
// Ports:
//   clock, ctrl_reset_n      : clock, synchronous active-low reset
//   i_set, i_set_idx         : mark a register busy (issue of a multdiv op)
//   i_clr, i_clr_idx         : mark a register free (multdiv writeback grant)
//   i_look_a/b/c, o_hit_a/b/c: three combinational busy lookups
//   o_busy                   : full busy vector
// A set and a clear of the same index in one cycle leaves the bit set, since
// the new issue is younger than the result being retired. Bit 0 never sets.
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_wb_pkg::*;
(
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  i_set,
    input  logic [REG_ADDR_W-1:0] i_set_idx,
    input  logic                  i_clr,
    input  logic [REG_ADDR_W-1:0] i_clr_idx,
    input  logic [REG_ADDR_W-1:0] i_look_a,
    input  logic [REG_ADDR_W-1:0] i_look_b,
    input  logic [REG_ADDR_W-1:0] i_look_c,
    output logic                  o_hit_a,
    output logic                  o_hit_b,
    output logic                  o_hit_c,
    output logic [NUM_REGS-1:0]   o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_next;

    // Build one-hot set/clear masks and the next busy vector (set dominates).
    always_comb begin
        w_set_mask = {NUM_REGS{1'b0}};
        w_clr_mask = {NUM_REGS{1'b0}};
        if (i_set) begin
            w_set_mask[i_set_idx] = 1'b1;
        end else begin
            w_set_mask = {NUM_REGS{1'b0}};
        end
        if (i_clr) begin
            w_clr_mask[i_clr_idx] = 1'b1;
        end else begin
            w_clr_mask = {NUM_REGS{1'b0}};
        end
        w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_busy <= {NUM_REGS{1'b0}};
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign o_hit_a = r_busy[i_look_a];
    assign o_hit_b = r_busy[i_look_b];
    assign o_hit_c = r_busy[i_look_c];
    assign o_busy  = r_busy;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates ALU and multdiv writeback requests onto a single register-file
// write port, tracks outstanding multdiv destinations for decode hazards and
// optionally forwards the in-flight write.
// Parameter STARVE_LIMIT (1..15): consecutive multdiv losses before the
// multdiv port is given one forced grant cycle.
// Ports:
//   clock, ctrl_reset_n            : clock, synchronous active-low reset
//   alu_valid/rd/data, alu_ready   : ALU writeback request and accept
//   md_issue, md_issue_rd          : multdiv issue (marks destination busy)
//   md_valid/rd/data, md_ready     : multdiv writeback request and accept
//   ctrl_readRegA/B                : decode-stage read addresses
//   ctrl_writeEnable/WriteReg,
//   data_writeReg                  : registered register-file write port
//   stall                          : decode hazard stall
//   byp_hitA/B, byp_data           : bypass of the in-flight write
// Build option: define REGFILE_WB_BYPASS_EN to enable the bypass outputs;
// otherwise they are tied to zero.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
)(
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [REG_DATA_W-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  md_issue,
    input  logic [REG_ADDR_W-1:0] md_issue_rd,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [REG_DATA_W-1:0] md_data,
    output logic                  md_ready,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
    input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [REG_DATA_W-1:0] data_writeReg,
    output logic                  stall,
    output logic                  byp_hitA,
    output logic                  byp_hitB,
    output logic [REG_DATA_W-1:0] byp_data
);

    localparam logic [STARVE_CNT_W-1:0] LP_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [STARVE_CNT_W-1:0] r_starve;
    logic [STARVE_CNT_W-1:0] w_starve_next;
    logic                    w_starve_inc;
    logic                    w_alu_grant;
    logic                    w_md_grant;
    logic                    w_stall;
    logic                    w_busy_a;
    logic                    w_busy_b;
    logic                    w_busy_alu;
    logic [NUM_REGS-1:0]     w_busy;
    logic                    r_we;
    logic [REG_ADDR_W-1:0]   r_wreg;
    logic [REG_DATA_W-1:0]   r_wdata;

    regfile_scoreboard u_scoreboard (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .i_set        (md_issue),
        .i_set_idx    (md_issue_rd),
        .i_clr        (w_md_grant),
        .i_clr_idx    (md_rd),
        .i_look_a     (ctrl_readRegA),
        .i_look_b     (ctrl_readRegB),
        .i_look_c     (alu_rd),
        .o_hit_a      (w_busy_a),
        .o_hit_b      (w_busy_b),
        .o_hit_c      (w_busy_alu),
        .o_busy       (w_busy)
    );

    // Decode hazard: any operand or the ALU destination still owed by multdiv.
    always_comb begin
        w_stall = 1'b0;
        if (ctrl_reset_n && (|w_busy)) begin
            w_stall = w_busy_a | w_busy_b | (alu_valid & w_busy_alu);
        end else begin
            w_stall = 1'b0;
        end
    end

    // Grant selection; a stalled ALU request must not overtake the pending
    // multdiv write to the same register, but multdiv may still retire.
    always_comb begin
        w_alu_grant = 1'b0;
        w_md_grant  = 1'b0;
        if (ctrl_reset_n) begin
            case (r_state)
                ST_ALU_PRI: begin
                    w_alu_grant = alu_valid & ~w_stall;
                    w_md_grant  = md_valid & ~w_alu_grant;
                end
                ST_MD_FORCE: begin
                    w_alu_grant = 1'b0;
                    w_md_grant  = md_valid;
                end
                default: begin
                    w_alu_grant = 1'b0;
                    w_md_grant  = 1'b0;
                end
            endcase
        end else begin
            w_alu_grant = 1'b0;
            w_md_grant  = 1'b0;
        end
    end

    // Starvation counter and next state. The forced cycle is entered only
    // on an increment reaching the limit, so a forced cycle that finds no
    // multdiv request does not re-trigger until multdiv loses again.
    always_comb begin
        w_starve_inc  = w_alu_grant & md_valid;
        w_starve_next = r_starve;
        w_state_next  = ST_ALU_PRI;
        if (w_md_grant) begin
            w_starve_next = {STARVE_CNT_W{1'b0}};
        end else if (w_starve_inc) begin
            w_starve_next = sat_inc(r_starve);
        end else begin
            w_starve_next = r_starve;
        end
        case (r_state)
            ST_ALU_PRI: begin
                if (w_starve_inc && (w_starve_next >= LP_LIMIT)) begin
                    w_state_next = ST_MD_FORCE;
                end else begin
                    w_state_next = ST_ALU_PRI;
                end
            end
            ST_MD_FORCE: w_state_next = ST_ALU_PRI;
            default:     w_state_next = ST_ALU_PRI;
        endcase
    end

    // State, counter and the registered register-file write port.
    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            r_state  <= ST_ALU_PRI;
            r_starve <= {STARVE_CNT_W{1'b0}};
            r_we     <= 1'b0;
            r_wreg   <= {REG_ADDR_W{1'b0}};
            r_wdata  <= {REG_DATA_W{1'b0}};
        end else begin
            r_state  <= w_state_next;
            r_starve <= w_starve_next;
            if (w_alu_grant) begin
                r_we    <= (alu_rd != 5'd0);
                r_wreg  <= alu_rd;
                r_wdata <= alu_data;
            end else if (w_md_grant) begin
                r_we    <= (md_rd != 5'd0);
                r_wreg  <= md_rd;
                r_wdata <= md_data;
            end else begin
                r_we    <= 1'b0;
            end
        end
    end

    assign alu_ready        = w_alu_grant;
    assign md_ready         = w_md_grant;
    assign stall            = w_stall;
    assign ctrl_writeEnable = r_we;
    assign ctrl_writeReg    = r_wreg;
    assign data_writeReg    = r_wdata;

`ifdef REGFILE_WB_BYPASS_EN
    // The register file cannot return a value written this same cycle, so
    // the write in flight is forwarded to decode.
    assign byp_hitA = ctrl_reset_n & r_we & (r_wreg != 5'd0) & (r_wreg == ctrl_readRegA);
    assign byp_hitB = ctrl_reset_n & r_we & (r_wreg != 5'd0) & (r_wreg == ctrl_readRegB);
    assign byp_data = ctrl_reset_n ? r_wdata : 32'd0;
`else
    assign byp_hitA = 1'b0;
    assign byp_hitB = 1'b0;
    assign byp_data = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clock;
    logic        ctrl_reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        stall;
    logic        byp_hitA;
    logic        byp_hitB;
    logic [31:0] byp_data;

    int errors = 0;
    int checks = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .alu_valid        (alu_valid),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .alu_ready        (alu_ready),
        .md_issue         (md_issue),
        .md_issue_rd      (md_issue_rd),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .stall            (stall),
        .byp_hitA         (byp_hitA),
        .byp_hitB         (byp_hitB),
        .byp_data         (byp_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        md_issue = 1'b0; md_issue_rd = 5'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
        ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    endtask

    task automatic apply_reset();
        idle();
        ctrl_reset_n = 1'b0;
        tick();
        tick();
        ctrl_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_reset_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = $urandom;
        md_issue = 1'b1; md_issue_rd = 5'd4;
        md_valid = 1'b1; md_rd = 5'd4; md_data = $urandom;
        ctrl_readRegA = 5'd4; ctrl_readRegB = 5'd3;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({alu_ready, md_ready, stall, byp_hitA, byp_hitB, ctrl_writeEnable,
                 ctrl_writeReg, data_writeReg, byp_data} !== 75'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: ar=%b mr=%b st=%b ha=%b hb=%b we=%b wr=%0d wd=%h bd=%h, want all 0",
                         c, alu_ready, md_ready, stall, byp_hitA, byp_hitB, ctrl_writeEnable,
                         ctrl_writeReg, data_writeReg, byp_data);
            end
        end
        ctrl_reset_n = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) begin
            ctrl_readRegA = 5'(i);
            #1;
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy_clear reg %0d: stall=%b want 0", i, stall);
            end
        end
        tick();
        checks++;
        if (ctrl_writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_write: we=%b want 0", ctrl_writeEnable);
        end
    endtask

    task automatic test_basic_write();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_alu_ready: got %b want 1", alu_ready);
        end
        checks++;
        if (md_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_md_ready: got %b want 0", md_ready);
        end
        tick();
        idle();
        checks++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL basic_write: we=%b reg=%0d data=%h want 1/5/deadbeef",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tick();
        checks++;
        if (ctrl_writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL basic_write_one_cycle: we=%b want 0", ctrl_writeEnable);
        end
    endtask

    task automatic test_starvation();
        logic [4:0] alu_pat;
        alu_pat = 5'b10111;
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
        md_valid = 1'b1; md_rd = 5'd2; md_data = 32'hB2B2B2B2;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (alu_ready !== alu_pat[k]) begin
                errors++;
                $display("FAIL starve_alu cycle %0d: got %b want %b", k, alu_ready, alu_pat[k]);
            end
            checks++;
            if (md_ready !== ~alu_pat[k]) begin
                errors++;
                $display("FAIL starve_md cycle %0d: got %b want %b", k, md_ready, ~alu_pat[k]);
            end
            tick();
            if (k == 3) begin
                checks++;
                if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd2, 32'hB2B2B2B2}) begin
                    errors++;
                    $display("FAIL starve_md_write: we=%b reg=%0d data=%h want 1/2/b2b2b2b2",
                             ctrl_writeEnable, ctrl_writeReg, data_writeReg);
                end
            end
        end
        idle();
    endtask

    task automatic test_hazard();
        apply_reset();
        md_issue = 1'b1; md_issue_rd = 5'd7;
        tick();
        md_issue = 1'b0;
        ctrl_readRegA = 5'd7;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({stall, alu_ready} !== 2'b10) begin
                errors++;
                $display("FAIL hazard_stall cycle %0d: stall=%b alu_ready=%b want 1/0", c, stall, alu_ready);
            end
            tick();
        end
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h00000777;
        #1;
        checks++;
        if ({md_ready, stall} !== 2'b11) begin
            errors++;
            $display("FAIL hazard_grant_cycle: md_ready=%b stall=%b want 1/1", md_ready, stall);
        end
        tick();
        md_valid = 1'b0;
        #1;
        checks++;
        if ({stall, alu_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hazard_release: stall=%b alu_ready=%b want 0/1", stall, alu_ready);
        end
        checks++;
        if ({ctrl_writeEnable, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd7, 32'h00000777}) begin
            errors++;
            $display("FAIL hazard_md_write: we=%b reg=%0d data=%h want 1/7/00000777",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tick();
        alu_valid = 1'b0;
        md_issue = 1'b1; md_issue_rd = 5'd7;
        md_valid = 1'b1; md_rd = 5'd7;
        tick();
        md_issue = 1'b0; md_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL hazard_set_wins: stall=%b want 1", stall);
        end
        md_valid = 1'b1;
        tick();
        md_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL hazard_set_wins_clear: stall=%b want 0", stall);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0BAD0BAD;
        #1;
        checks++;
        if (alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_alu_ready: got %b want 1", alu_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (ctrl_writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_write: we=%b want 0", ctrl_writeEnable);
        end
        md_issue = 1'b1; md_issue_rd = 5'd0;
        tick();
        md_issue = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_stall: stall=%b want 0", stall);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44444444;
        md_issue = 1'b1; md_issue_rd = 5'd9;
        tick();
        md_issue = 1'b0;
        ctrl_reset_n = 1'b0;
        ctrl_readRegA = 5'd9;
        #1;
        checks++;
        if ({alu_ready, stall} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_gate: alu_ready=%b stall=%b want 0/0", alu_ready, stall);
        end
        tick();
        checks++;
        if (ctrl_writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL midreset_write: we=%b want 0", ctrl_writeEnable);
        end
        ctrl_reset_n = 1'b1;
        alu_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy: stall=%b want 0", stall);
        end
        tick();
        checks++;
        if (ctrl_writeEnable !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after: we=%b want 0", ctrl_writeEnable);
        end
        idle();
    endtask

    task automatic test_bypass();
        apply_reset();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h12345678;
        tick();
        alu_valid = 1'b0;
        ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd9;
        #1;
`ifdef REGFILE_WB_BYPASS_EN
        checks++;
        if ({byp_hitA, byp_hitB, byp_data} !== {1'b0, 1'b1, 32'h12345678}) begin
            errors++;
            $display("FAIL bypass_hitB: ha=%b hb=%b data=%h want 0/1/12345678", byp_hitA, byp_hitB, byp_data);
        end
        ctrl_readRegA = 5'd9;
        #1;
        checks++;
        if (byp_hitA !== 1'b1) begin
            errors++;
            $display("FAIL bypass_hitA: got %b want 1", byp_hitA);
        end
        tick();
        checks++;
        if ({byp_hitA, byp_hitB} !== 2'b00) begin
            errors++;
            $display("FAIL bypass_expire: ha=%b hb=%b want 0/0", byp_hitA, byp_hitB);
        end
`else
        ctrl_readRegA = 5'd9;
        #1;
        checks++;
        if ({byp_hitA, byp_hitB, byp_data} !== 34'd0) begin
            errors++;
            $display("FAIL bypass_disabled: ha=%b hb=%b data=%h want 0", byp_hitA, byp_hitB, byp_data);
        end
`endif
        idle();
    endtask

    task automatic test_random();
        bit          m_busy [32];
        int          m_starve;
        bit          m_force;
        bit          m_we;
        logic [4:0]  m_wreg;
        logic [31:0] m_wdata;
        bit          e_ar, e_mr, e_st, e_ha, e_hb;
        logic [31:0] e_bd;
        apply_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_starve = 0; m_force = 1'b0; m_we = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
        for (int n = 0; n < 600; n++) begin
            ctrl_reset_n  = ($urandom_range(0, 59) != 0);
            alu_valid     = ($urandom_range(0, 3) != 0);
            alu_rd        = 5'($urandom_range(0, 7));
            alu_data      = $urandom;
            md_issue      = ($urandom_range(0, 3) == 0);
            md_issue_rd   = 5'($urandom_range(0, 7));
            md_valid      = ($urandom_range(0, 1) != 0);
            md_rd         = 5'($urandom_range(0, 7));
            md_data       = $urandom;
            ctrl_readRegA = 5'($urandom_range(0, 7));
            ctrl_readRegB = 5'($urandom_range(0, 7));
            #1;
            if (!ctrl_reset_n) begin
                e_st = 1'b0; e_ar = 1'b0; e_mr = 1'b0;
            end else begin
                e_st = m_busy[ctrl_readRegA] || m_busy[ctrl_readRegB] || (alu_valid && m_busy[alu_rd]);
                e_ar = !m_force && alu_valid && !e_st;
                e_mr = md_valid && !e_ar;
            end
            checks++;
            if ({alu_ready, md_ready, stall} !== {e_ar, e_mr, e_st}) begin
                errors++;
                $display("FAIL random_arb cycle %0d: ar/mr/st=%b%b%b want %b%b%b",
                         n, alu_ready, md_ready, stall, e_ar, e_mr, e_st);
            end
            if (!ctrl_reset_n) begin
                foreach (m_busy[i]) m_busy[i] = 1'b0;
                m_starve = 0; m_force = 1'b0; m_we = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
            end else begin
                if (e_mr) m_busy[md_rd] = 1'b0;
                if (md_issue && md_issue_rd != 5'd0) m_busy[md_issue_rd] = 1'b1;
                m_force = 1'b0;
                if (e_mr) begin
                    m_starve = 0;
                end else if (e_ar && md_valid) begin
                    if (m_starve < 15) m_starve++;
                    if (m_starve >= LIMIT) m_force = 1'b1;
                end
                if (e_ar) begin
                    m_we = (alu_rd != 5'd0); m_wreg = alu_rd; m_wdata = alu_data;
                end else if (e_mr) begin
                    m_we = (md_rd != 5'd0); m_wreg = md_rd; m_wdata = md_data;
                end else begin
                    m_we = 1'b0;
                end
            end
            tick();
            checks++;
            if (ctrl_writeEnable !== m_we || (m_we && {ctrl_writeReg, data_writeReg} !== {m_wreg, m_wdata})) begin
                errors++;
                $display("FAIL random_write cycle %0d: we=%b reg=%0d data=%h want %b/%0d/%h",
                         n, ctrl_writeEnable, ctrl_writeReg, data_writeReg, m_we, m_wreg, m_wdata);
            end
`ifdef REGFILE_WB_BYPASS_EN
            e_ha = ctrl_reset_n && m_we && m_wreg != 5'd0 && m_wreg == ctrl_readRegA;
            e_hb = ctrl_reset_n && m_we && m_wreg != 5'd0 && m_wreg == ctrl_readRegB;
            e_bd = ctrl_reset_n ? m_wdata : 32'd0;
`else
            e_ha = 1'b0; e_hb = 1'b0; e_bd = 32'd0;
`endif
            checks++;
            if ({byp_hitA, byp_hitB, byp_data} !== {e_ha, e_hb, e_bd}) begin
                errors++;
                $display("FAIL random_bypass cycle %0d: ha=%b hb=%b data=%h want %b/%b/%h",
                         n, byp_hitA, byp_hitB, byp_data, e_ha, e_hb, e_bd);
            end
        end
        ctrl_reset_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        ctrl_reset_n = 1'b0;
        test_reset();
        test_basic_write();
        test_starvation();
        test_hazard();
        test_zero_reg();
        test_reset_mid();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive MD losses before a forced MD grant; legal range 1..15.
REQ-002 Ports are as follows; reset is synchronous and active-low.
- clock, in, 1: sole clock; all state updates on the rising edge.
- ctrl_reset_n, in, 1: synchronous active-low reset.
- alu_valid, in, 1: ALU writeback request.
- alu_rd, in, 5: ALU destination register.
- alu_data, in, 32: ALU result.
- alu_ready, out, 1: ALU request accepted this cycle.
- md_issue, in, 1: multdiv op issued this cycle.
- md_issue_rd, in, 5: destination of the issued op.
- md_valid, in, 1: multdiv writeback request.
- md_rd, in, 5: multdiv destination register.
- md_data, in, 32: multdiv result.
- md_ready, out, 1: multdiv request accepted this cycle.
- ctrl_readRegA, in, 5: decode-stage read address A.
- ctrl_readRegB, in, 5: decode-stage read address B.
- ctrl_writeEnable, out, 1: register-file write enable.
- ctrl_writeReg, out, 5: register-file write address.
- data_writeReg, out, 32: register-file write data.
- stall, out, 1: decode-stage hazard stall.
- byp_hitA, out, 1: bypass valid for operand A.
- byp_hitB, out, 1: bypass valid for operand B.
- byp_data, out, 32: bypass data.

Function
REQ-003 Arbitration is combinational and accepts at most one request per cycle; alu_ready and md_ready are never both 1.
REQ-004 ST_ALU_PRI:
- alu_valid=1: ALU is granted.
- Otherwise md_valid=1: MD is granted.
REQ-005 Starvation counter:
- Increments on each cycle in which md_valid=1 and ALU is granted.
- Clears to 0 on every MD grant.
- Holds otherwise.
REQ-006 ST_ALU_PRI -> ST_MD_FORCE when the counter reaches STARVE_LIMIT.
REQ-007 ST_MD_FORCE:
- MD is granted if md_valid=1; alu_ready=0 regardless.
- Returns to ST_ALU_PRI after one cycle, with or without a grant.
REQ-008 A granted request registers its rd and data onto ctrl_writeReg and data_writeReg at the next edge; ctrl_writeEnable=1 for exactly that one cycle, giving one-cycle latency.
REQ-009 A granted request with rd=0 is accepted but produces ctrl_writeEnable=0.
REQ-010 Scoreboard: 32-bit busy vector.
- md_issue=1 with md_issue_rd!=0 sets busy[md_issue_rd].
- An MD grant clears busy[md_rd].
- Set and clear of the same index in the same cycle: set wins.
- busy[0] is always 0.
REQ-011 stall=1 whenever any of the following is busy: ctrl_readRegA, ctrl_readRegB, or alu_rd while alu_valid=1.
REQ-012 While stall=1 the ALU is not granted (WAW protection); MD arbitration is unaffected.
REQ-013 An MD grant for a non-busy rd is legal and writes normally.

Reset
REQ-014 With ctrl_reset_n=0 at an edge:
- State goes to ST_ALU_PRI; counter and busy vector go to 0.
- ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
REQ-015 While ctrl_reset_n=0: alu_ready=0, md_ready=0, stall=0, byp_hitA=0, byp_hitB=0, byp_data=0.
REQ-016 Reset asserted mid-operation discards any pending write and all in-flight busy bits; no write is issued on the following cycle.

Configuration
REQ-017 Macro REGFILE_WB_BYPASS_EN, defined:
- byp_hitA=1 when ctrl_writeEnable=1, ctrl_writeReg!=0, and ctrl_writeReg==ctrl_readRegA.
- byp_hitB=1 under the same conditions against ctrl_readRegB.
- byp_data=data_writeReg.
- This covers the cycle in which the register file read of the same address is not valid.
REQ-018 Macro REGFILE_WB_BYPASS_EN undefined: byp_hitA, byp_hitB and byp_data are constant 0, with no extra logic.

Structure
REQ-019 Shared package regfile_wb_pkg holds:
- state encoding (ST_ALU_PRI, ST_MD_FORCE);
- REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32.
REQ-020 The scoreboard is a separate sub-module, regfile_scoreboard, with set, clear, three lookup ports and the 32-bit busy vector; all other logic is flat.

Verification
REQ-021 Reset: drive ctrl_reset_n=0 for 2 cycles with all inputs active -> all outputs 0; after release, busy vector is 0.
REQ-022 Basic write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1; next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF.
REQ-023 Starvation, STARVE_LIMIT=3: alu_valid and md_valid held 1 -> ALU granted 3 cycles, MD granted on the 4th, ALU on the 5th.
REQ-024 Hazard: md_issue with rd=7, then ctrl_readRegA=7 -> stall=1 until the cycle after MD rd=7 is granted; stall=0 on the cycle after that grant.
REQ-025 Zero register: alu_rd=0 request -> alu_ready=1, ctrl_writeEnable stays 0; md_issue_rd=0 -> stall never asserts.
REQ-026 Bypass (macro defined): ALU write rd=9, 0x12345678, with ctrl_readRegB=9 in the write cycle -> byp_hitB=1, byp_data=0x12345678, byp_hitA=0.
